// File: rtl/iter_mult.sv
// rtl/iter_mult.sv - iterative unsigned shift-add multiplier with start/busy/done handshake
module iter_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateType;

    stateType state;
    stateType nextState;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mplr;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] accSum;
    logic [WIDTH:0]   carry;
    logic             cOut;
    logic             lastIter;

    // The partial product is added only when the current multiplier LSB is set.
    assign addend   = mplr[0] ? mcand : '0;
    assign carry[0] = 1'b0;
    assign cOut     = carry[WIDTH];
    assign lastIter = (cnt == LAST_CNT);

    // Ripple-carry adder: one full-adder cell per bit, carry chained LSB to MSB.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : gFullAdder
            assign accSum[gi]  = acc[gi] ^ addend[gi] ^ carry[gi];
            assign carry[gi+1] = (acc[gi] & addend[gi]) |
                                 (acc[gi] & carry[gi])  |
                                 (addend[gi] & carry[gi]);
        end
    endgenerate

    // State register; reset always returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode; start only matters in IDLE and DONE always falls back to IDLE.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (lastIter) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Handshake outputs are decoded from state only, so no input reaches them combinationally.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Datapath: load operands on accept, add-and-shift once per RUN cycle, publish P on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            acc   <= '0;
            mplr  <= '0;
            cnt   <= '0;
            P     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= A;
                        mplr  <= B;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc  <= {cOut, accSum[WIDTH-1:1]};
                    mplr <= {accSum[0], mplr[WIDTH-1:1]};
                    cnt  <= cnt + 1'b1;
                    if (lastIter) begin
                        P <= {cOut, accSum, mplr[WIDTH-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_mult.sv
// tb/tb_iter_mult.sv - self-checking bench for iter_mult against an arithmetic reference
module tb_iter_mult;

    localparam int W = 16;
    localparam int LAT = W + 1;
    localparam int PERIOD = W + 2;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           busy;
    logic           done;
    logic [2*W-1:0] P;

    int compared;
    int mismatched;
    logic [2*W-1:0] modelP;

    iter_mult #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One multiply through the handshake; expected product is plain a*b.
    task automatic runMult(input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        logic busyOk;
        logic pOk;
        logic [2*W-1:0] expP;
        expP = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        start = 1'b1;
        A = a;
        B = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        lat = 0;
        busyOk = 1'b1;
        pOk = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) busyOk = 1'b0;
            if (P !== modelP) pOk = 1'b0;
            A = W'($urandom);
            B = W'($urandom);
            @(negedge clk);
        end
        checkVal("latency", 64'(lat), 64'(LAT));
        checkVal("busy_run", 64'(busyOk), 64'd1);
        checkVal("p_hold_run", 64'(pOk), 64'd1);
        checkVal("busy_done", 64'(busy), 64'd1);
        checkVal("product", 64'(P), 64'(expP));
        modelP = expP;
        @(negedge clk);
        checkVal("busy_after", 64'(busy), 64'd0);
        checkVal("done_after", 64'(done), 64'd0);
    endtask

    logic [W-1:0] aArr [0:63];
    logic [W-1:0] bArr [0:63];

    initial begin
        logic pOk;
        logic sawDone;
        logic expDone;
        logic expBusy;
        logic [2*W-1:0] expP;
        compared = 0;
        mismatched = 0;
        modelP = '0;
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(negedge clk);
        checkVal("reset_busy", 64'(busy), 64'd0);
        checkVal("reset_done", 64'(done), 64'd0);
        checkVal("reset_p", 64'(P), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        runMult(16'd3, 16'd5);
        runMult(16'hFFFF, 16'hFFFF);
        runMult(16'h8000, 16'h0002);
        runMult(16'h1234, 16'h0000);
        runMult(16'h0000, 16'hABCD);

        for (int t = 0; t < 12; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            runMult(W'($urandom), W'($urandom));
        end

        // start held high with operands changing every cycle
        for (int n = 0; n < 64; n++) begin
            aArr[n] = W'($urandom);
            bArr[n] = W'($urandom);
        end
        for (int n = 0; n < 54; n++) begin
            start = 1'b1;
            A = aArr[n];
            B = bArr[n];
            @(posedge clk);
            @(negedge clk);
            expDone = ((n % PERIOD) == (LAT - 1));
            expBusy = (((n + 1) % PERIOD) != 0);
            checkVal("held_done", 64'(done), 64'(expDone));
            checkVal("held_busy", 64'(busy), 64'(expBusy));
            if (expDone) begin
                expP = {{W{1'b0}}, aArr[n-LAT+1]} * {{W{1'b0}}, bArr[n-LAT+1]};
                checkVal("held_product", 64'(P), 64'(expP));
                modelP = expP;
            end
        end
        start = 1'b0;
        @(negedge clk);
        checkVal("held_idle", 64'(busy), 64'd0);

        // P holds through idle and through a following multiply's RUN cycles
        runMult(16'd7, 16'd9);
        pOk = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (P !== 32'd63) pOk = 1'b0;
            @(negedge clk);
        end
        checkVal("p_hold_idle", 64'(pOk), 64'd1);
        runMult(W'($urandom), W'($urandom));

        // reset mid-RUN discards the in-flight result
        runMult(16'd7, 16'd9);
        start = 1'b1;
        A = 16'd2;
        B = 16'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkVal("midrst_busy", 64'(busy), 64'd0);
        checkVal("midrst_done", 64'(done), 64'd0);
        checkVal("midrst_p", 64'(P), 64'd0);
        modelP = '0;
        sawDone = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done || busy) sawDone = 1'b1;
        end
        checkVal("midrst_quiet", 64'(sawDone), 64'd0);

        // rst and start together: rst wins
        rst = 1'b1;
        start = 1'b1;
        A = 16'd5;
        B = 16'd5;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        checkVal("rst_start_busy", 64'(busy), 64'd0);
        @(negedge clk);
        checkVal("rst_start_idle", 64'(busy), 64'd0);
        runMult(16'd5, 16'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
